// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline types and constants.
// Used by the fetch sequencer and its output FIFO.
package rv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} entries toward IF/ID.
// Synchronous clear dominates push and pop in the same cycle.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_wr;
    logic           w_rd;

    assign full  = (r_count == CNT_FULL);
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];
    assign w_wr  = push & (~full | pop);
    assign w_rd  = pop & ~empty;

    // Storage, pointers and occupancy; clear only rewinds pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + {{AW{1'b0}}, w_wr}
                               - {{AW{1'b0}}, w_rd};
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the ROM and
// buffers {pc, instr} toward IF/ID with redirect and start/stop.
module fetch_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_pc,
    input  logic [31:0]      imem_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic             busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_pc;
    logic             r_misalign;
    logic [CNT_W-1:0] r_fetch_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    fetch_entry_t     w_head;
    fetch_entry_t     w_din;

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = (r_state == RUN) & ~redirect_valid
                     & (~w_full | w_pop);
    assign w_din     = '{pc: r_pc, instr: imem_instr};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop & ~redirect_valid),
        .clear (redirect_valid),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // Run/idle transitions; start and stop only act in their own state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN:  if (stop)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // PC: redirect wins, otherwise advance on every push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= align_pc(redirect_pc);
        end else if (w_push) begin
            r_pc <= r_pc + 32'(INSTR_BYTES);
        end
    end

    // Sticky flag for redirect targets off a word boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    // Count of entries written into the FIFO since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_fetch_count <= '0;
        else if (w_push) r_fetch_count <= r_fetch_count + CNT_W'(1);
    end

    assign imem_pc      = r_pc;
    assign out_pc       = w_head.pc;
    assign out_instr    = w_head.instr;
    assign busy         = (r_state == RUN);
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a combinational ROM model.
// Expected {pc, instr} pairs are queued and checked on each pop.
module tb_fetch_ctrl;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        busy;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;
    fetch_entry_t sb[$];

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2),
        .CNT_W    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .busy           (busy),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [5:0] idx;
        idx = a[7:2];
        case (idx)
            6'd0:    return 32'h0010_0093;
            6'd1:    return 32'h0020_0113;
            6'd2:    return 32'h0020_81B3;
            6'd3:    return 32'h0000_0013;
            6'd4:    return 32'h0000_0013;
            default: return {16'hC0DE, 10'd0, idx};
        endcase
    endfunction

    always_comb imem_instr = rom_word(imem_pc);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_e(input logic [31:0] pc);
        sb.push_back({pc, rom_word(pc)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consumer side: every accepted, non-killed head must match.
    always @(negedge clk) begin : mon
        fetch_entry_t e;
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                check("sb_extra_pop", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_pc", out_pc, e.pc);
                check("sb_instr", out_instr, e.instr);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset values, then async reset mid-operation
        step();
        step();
        rst = 1'b0;
        check("rst_pc", imem_pc, 32'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_outpc", out_pc, 32'h0);
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h22;
        step();
        start = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        check("pre_busy", busy, 1'b1);
        check("pre_cnt", fetch_count, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", imem_pc, 32'h0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_cnt", fetch_count, 32'd0);
        check("arst_mis", misalign_err, 1'b0);
        check("arst_outpc", out_pc, 32'h0);
        step();
        rst = 1'b0;

        // 2: streaming with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) expect_e(32'(i * 4));
        start = 1'b1;
        step();
        start = 1'b0;
        check("lat_n1", out_valid, 1'b0);
        step();
        check("lat_n2", out_valid, 1'b1);
        step();
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("st_cnt", fetch_count, 32'd5);
        check("st_valid", out_valid, 1'b0);
        check("st_busy", busy, 1'b0);
        check("st_pc", imem_pc, 32'd20);
        check("st_sb", sb.size(), 0);

        // 3: backpressure from start
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_e(32'(i * 4));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("bp_pc", imem_pc, 32'd8);
        check("bp_hpc", out_pc, 32'd0);
        check("bp_hin", out_instr, 32'h0010_0093);
        check("bp_cnt", fetch_count, 32'd2);
        out_ready = 1'b1;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("bp_v5", out_valid, 1'b1);
        step();
        check("bp_v6", out_valid, 1'b1);
        step();
        check("bp_end", out_valid, 1'b0);
        check("bp_sb", sb.size(), 0);
        check("bp_cnt4", fetch_count, 32'd4);
        check("bp_pc16", imem_pc, 32'd16);

        // 4: redirect while full kills the same-cycle pop
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        expect_e(32'h10);
        expect_e(32'h14);
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rd_kill", out_valid, 1'b0);
        check("rd_pc", imem_pc, 32'h10);
        step();
        check("rd_head", out_pc, 32'h10);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("rd_end", out_valid, 1'b0);
        check("rd_sb", sb.size(), 0);
        check("rd_cnt", fetch_count, 32'd4);

        // 5: misaligned redirect together with start in IDLE
        expect_e(32'h4);
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h6;
        step();
        start = 1'b0;
        redirect_valid = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("mis_head", out_pc, 32'h4);
        check("mis_err", misalign_err, 1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("mis_sticky", misalign_err, 1'b1);
        check("mis_pc0", imem_pc, 32'h0);
        check("mis_sb", sb.size(), 0);

        // 6: stop with two buffered entries, then restart
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("ss_busy", busy, 1'b0);
        check("ss_valid", out_valid, 1'b1);
        expect_e(32'h0);
        expect_e(32'h4);
        out_ready = 1'b1;
        step();
        step();
        check("ss_drain", out_valid, 1'b0);
        check("ss_pc", imem_pc, 32'd8);
        step();
        check("ss_frozen", imem_pc, 32'd8);
        expect_e(32'h8);
        expect_e(32'hC);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("ss_resume", out_pc, 32'h8);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("ss_end", out_valid, 1'b0);
        check("ss_sb", sb.size(), 0);
        check("ss_pc16", imem_pc, 32'd16);

        // 7: PC wraps from 0xFFFF_FFFC to 0
        out_ready = 1'b0;
        expect_e(32'hFFFF_FFFC);
        expect_e(32'h0);
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        start = 1'b0;
        redirect_valid = 1'b0;
        step();
        check("wr_pc0", imem_pc, 32'h0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("wr_pc4", imem_pc, 32'h4);
        check("wr_head", out_pc, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        step();
        step();
        check("wr_end", out_valid, 1'b0);
        check("wr_sb", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
